// File: rtl/adc_idelay_autocal.sv
`default_nettype none
// ============================================================================
//  Module   : adc_idelay_autocal
//  Purpose  : IDELAY tap calibration for the FMC ADC data path. While the ADC
//             sends a known test word, each channel in turn (ch0 first) is
//             swept over every tap. The widest contiguous run of passing taps
//             is found and its centre is loaded. A manual mode keeps the
//             PC-driven load path (value / select / rising-edge load).
//  Ports    : sys_clk, rst          clock, synchronous active-high reset
//             start_i, mode_i       start pulse, 0 = auto / 1 = manual
//             man_tap_i, man_chan_sel_i, man_load_i   manual load path
//             pattern_i             expected test word
//             adc_data_i, adc_valid_i   captured words and sample strobes
//             idelay_rdy_i          IDELAYCTRL ready
//             delay_val_o, delay_chan_sel_o, delay_load_o   IDELAY control
//             busy_o, done_o, fail_o, tap_sel_o         status / results
//  Revision : 1.0  initial release
// ============================================================================
module adc_idelay_autocal #(
  parameter int G_NUM_CHANNELS  = 4,
  parameter int G_NUM_BITS      = 17,
  parameter int G_TAP_WIDTH     = 5,
  parameter int G_SETTLE_CYCLES = 16,
  parameter int G_CHECK_SAMPLES = 64,
  parameter int G_MIN_WINDOW    = 3
) (
  input  logic                                 sys_clk,
  input  logic                                 rst,
  input  logic                                 start_i,
  input  logic                                 mode_i,
  input  logic [G_TAP_WIDTH-1:0]               man_tap_i,
  input  logic [G_NUM_CHANNELS-1:0]            man_chan_sel_i,
  input  logic                                 man_load_i,
  input  logic [G_NUM_BITS-1:0]                pattern_i,
  input  logic [G_NUM_CHANNELS*G_NUM_BITS-1:0] adc_data_i,
  input  logic [G_NUM_CHANNELS-1:0]            adc_valid_i,
  input  logic                                 idelay_rdy_i,
  output logic [G_TAP_WIDTH-1:0]               delay_val_o,
  output logic [G_NUM_CHANNELS-1:0]            delay_chan_sel_o,
  output logic                                 delay_load_o,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic [G_NUM_CHANNELS-1:0]            fail_o,
  output logic [G_NUM_CHANNELS*G_TAP_WIDTH-1:0] tap_sel_o
);

  localparam int CH_W    = (G_NUM_CHANNELS > 1) ? $clog2(G_NUM_CHANNELS) : 1;
  localparam int TAP_MAX = (2 ** G_TAP_WIDTH) - 1;
  localparam int TIMEOUT = 4 * G_CHECK_SAMPLES;
  localparam int CNT_W   = $clog2(TIMEOUT + G_SETTLE_CYCLES + 1) + 1;
  localparam int SMP_W   = $clog2(G_CHECK_SAMPLES + 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WAIT_RDY  = 4'd1,
    S_LOAD      = 4'd2,
    S_SETTLE    = 4'd3,
    S_CHECK     = 4'd4,
    S_EVAL      = 4'd5,
    S_APPLY     = 4'd6,
    S_NEXT_CHAN = 4'd7,
    S_DONE      = 4'd8
  } state_t;

  state_t                      state;
  logic [CH_W-1:0]             chan;
  logic [G_TAP_WIDTH-1:0]      tap;
  logic [CNT_W-1:0]            cnt;
  logic [SMP_W-1:0]            smp_cnt;
  logic                        tap_bad;
  logic [G_TAP_WIDTH-1:0]      run_len;
  logic [G_TAP_WIDTH-1:0]      run_start;
  logic [G_TAP_WIDTH-1:0]      best_len;
  logic [G_TAP_WIDTH-1:0]      best_start;
  logic                        man_load_q;

  logic [G_NUM_BITS-1:0]       chan_word;
  logic                        chan_valid;
  logic [G_NUM_CHANNELS-1:0]   chan_onehot;
  logic [G_TAP_WIDTH-1:0]      run_next;
  logic [G_TAP_WIDTH-1:0]      start_next;
  logic                        win_ok;
  logic [G_TAP_WIDTH-1:0]      final_tap;
  logic                        rdy_lost;

  assign chan_word   = adc_data_i[int'(chan)*G_NUM_BITS +: G_NUM_BITS];
  assign chan_valid  = adc_valid_i[chan];
  assign chan_onehot = G_NUM_CHANNELS'(1) << chan;

  // Run length is a tap-wide counter that saturates at the all-ones value.
  // This keeps best_start + best_len/2 inside the tap range: a full-range
  // window of 2^W taps centres on tap 2^(W-1)-1.
  assign run_next   = tap_bad ? '0 :
                      ((&run_len) ? run_len : run_len + 1'b1);
  assign start_next = (!tap_bad && (run_len == '0)) ? tap : run_start;

  assign win_ok    = (best_len >= G_TAP_WIDTH'(G_MIN_WINDOW));
  assign final_tap = win_ok ? (best_start + (best_len >> 1)) : '0;

  // Losing IDELAYCTRL ready only restarts a tap while that tap is being
  // loaded, settled, checked or scored. APPLY and NEXT_CHAN are single-cycle
  // steps after the last tap was already scored; re-running that tap would
  // count it twice in the window.
  assign rdy_lost = !idelay_rdy_i &&
                    ((state == S_LOAD) || (state == S_SETTLE) ||
                     (state == S_CHECK) || (state == S_EVAL));

  assign busy_o = (state != S_IDLE) && (state != S_DONE);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state            <= S_IDLE;
      chan             <= '0;
      tap              <= '0;
      cnt              <= '0;
      smp_cnt          <= '0;
      tap_bad          <= 1'b0;
      run_len          <= '0;
      run_start        <= '0;
      best_len         <= '0;
      best_start       <= '0;
      man_load_q       <= 1'b0;
      delay_val_o      <= '0;
      delay_chan_sel_o <= '0;
      delay_load_o     <= 1'b0;
      done_o           <= 1'b0;
      fail_o           <= '0;
      tap_sel_o        <= '0;
    end else begin
      man_load_q   <= man_load_i;
      delay_load_o <= 1'b0;

      if (rdy_lost) begin
        state   <= S_WAIT_RDY;
        cnt     <= '0;
        smp_cnt <= '0;
        tap_bad <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_i && !mode_i) begin
              done_o     <= 1'b0;
              fail_o     <= '0;
              tap_sel_o  <= '0;
              chan       <= '0;
              tap        <= '0;
              run_len    <= '0;
              run_start  <= '0;
              best_len   <= '0;
              best_start <= '0;
              state      <= S_WAIT_RDY;
            end else if (mode_i && man_load_i && !man_load_q) begin
              delay_load_o     <= 1'b1;
              delay_val_o      <= man_tap_i;
              delay_chan_sel_o <= man_chan_sel_i;
            end
          end

          S_WAIT_RDY: begin
            if (idelay_rdy_i) begin
              state <= S_LOAD;
            end
          end

          S_LOAD: begin
            delay_load_o     <= 1'b1;
            delay_val_o      <= tap;
            delay_chan_sel_o <= chan_onehot;
            cnt              <= '0;
            state            <= S_SETTLE;
          end

          S_SETTLE: begin
            if (cnt == CNT_W'(G_SETTLE_CYCLES - 1)) begin
              cnt     <= '0;
              smp_cnt <= '0;
              tap_bad <= 1'b0;
              state   <= S_CHECK;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          S_CHECK: begin
            cnt <= cnt + 1'b1;
            if (chan_valid) begin
              smp_cnt <= smp_cnt + 1'b1;
              if (chan_word != pattern_i) begin
                tap_bad <= 1'b1;
              end
            end
            // A final sample landing on the timeout cycle still counts.
            if (chan_valid && (smp_cnt == SMP_W'(G_CHECK_SAMPLES - 1))) begin
              state <= S_EVAL;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
              tap_bad <= 1'b1;
              state   <= S_EVAL;
            end
          end

          S_EVAL: begin
            run_len   <= run_next;
            run_start <= start_next;
            // Strictly greater: on equal-length runs the lower one is kept.
            if (run_next > best_len) begin
              best_len   <= run_next;
              best_start <= start_next;
            end
            if (tap == G_TAP_WIDTH'(TAP_MAX)) begin
              state <= S_APPLY;
            end else begin
              tap   <= tap + 1'b1;
              state <= S_LOAD;
            end
          end

          S_APPLY: begin
            tap_sel_o[int'(chan)*G_TAP_WIDTH +: G_TAP_WIDTH] <= final_tap;
            if (!win_ok) begin
              fail_o[chan] <= 1'b1;
            end
            delay_load_o     <= 1'b1;
            delay_val_o      <= final_tap;
            delay_chan_sel_o <= chan_onehot;
            state            <= S_NEXT_CHAN;
          end

          S_NEXT_CHAN: begin
            run_len    <= '0;
            run_start  <= '0;
            best_len   <= '0;
            best_start <= '0;
            if (chan == CH_W'(G_NUM_CHANNELS - 1)) begin
              state <= S_DONE;
            end else begin
              chan  <= chan + 1'b1;
              tap   <= '0;
              state <= S_LOAD;
            end
          end

          S_DONE: begin
            done_o <= 1'b1;
            state  <= S_IDLE;
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_idelay_autocal.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_idelay_autocal
//  Purpose  : Directed self-checking bench for adc_idelay_autocal with two
//             channels. An ADC model returns the test word on taps marked as
//             passing in a per-channel mask and a corrupted word otherwise,
//             tracking the tap currently loaded on each channel.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adc_idelay_autocal;

  localparam int NCH = 2;
  localparam int NB  = 17;
  localparam int TW  = 5;
  localparam int MAXP = 1024;

  logic                sys_clk;
  logic                rst;
  logic                start_i;
  logic                mode_i;
  logic [TW-1:0]       man_tap_i;
  logic [NCH-1:0]      man_chan_sel_i;
  logic                man_load_i;
  logic [NB-1:0]       pattern_i;
  logic [NCH*NB-1:0]   adc_data_i;
  logic [NCH-1:0]      adc_valid_i;
  logic                idelay_rdy_i;
  logic [TW-1:0]       delay_val_o;
  logic [NCH-1:0]      delay_chan_sel_o;
  logic                delay_load_o;
  logic                busy_o;
  logic                done_o;
  logic [NCH-1:0]      fail_o;
  logic [NCH*TW-1:0]   tap_sel_o;

  int total = 0;
  int bad   = 0;

  adc_idelay_autocal #(
    .G_NUM_CHANNELS (NCH),
    .G_NUM_BITS     (NB),
    .G_TAP_WIDTH    (TW),
    .G_SETTLE_CYCLES(16),
    .G_CHECK_SAMPLES(64),
    .G_MIN_WINDOW   (3)
  ) dut (
    .sys_clk         (sys_clk),
    .rst             (rst),
    .start_i         (start_i),
    .mode_i          (mode_i),
    .man_tap_i       (man_tap_i),
    .man_chan_sel_i  (man_chan_sel_i),
    .man_load_i      (man_load_i),
    .pattern_i       (pattern_i),
    .adc_data_i      (adc_data_i),
    .adc_valid_i     (adc_valid_i),
    .idelay_rdy_i    (idelay_rdy_i),
    .delay_val_o     (delay_val_o),
    .delay_chan_sel_o(delay_chan_sel_o),
    .delay_load_o    (delay_load_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .fail_o          (fail_o),
    .tap_sel_o       (tap_sel_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // ADC model and load-pulse recorder
  logic [31:0]   pass_mask [NCH];
  logic [TW-1:0] cur_tap   [NCH];
  int            cyc  = 0;
  int            pcnt = 0;
  int            stamp [MAXP];
  logic [TW-1:0] pval  [MAXP];
  logic [NCH-1:0] psel [MAXP];

  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      for (int k = 0; k < NCH; k++) cur_tap[k] <= '0;
    end else if (delay_load_o) begin
      if (pcnt < MAXP) begin
        stamp[pcnt] <= cyc;
        pval[pcnt]  <= delay_val_o;
        psel[pcnt]  <= delay_chan_sel_o;
      end
      pcnt <= pcnt + 1;
      for (int k = 0; k < NCH; k++)
        if (delay_chan_sel_o[k]) cur_tap[k] <= delay_val_o;
    end
  end

  always_comb begin
    adc_data_i = '0;
    for (int k = 0; k < NCH; k++)
      adc_data_i[k*NB +: NB] = pass_mask[k][cur_tap[k]] ? pattern_i : ~pattern_i;
  end

  function automatic logic [31:0] rng(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_done(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 30000; i++) begin
      if (done_o === 1'b1 && busy_o === 1'b0) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic run_cal(output bit timed_out);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_done(timed_out);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ticks(3);
    total++; if (delay_load_o !== 1'b0) begin bad++; $display("FAIL reset_load got=%b exp=0", delay_load_o); end
    total++; if (delay_val_o !== '0) begin bad++; $display("FAIL reset_val got=%0d exp=0", delay_val_o); end
    total++; if (delay_chan_sel_o !== '0) begin bad++; $display("FAIL reset_sel got=%b exp=00", delay_chan_sel_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done_o); end
    total++; if (fail_o !== '0) begin bad++; $display("FAIL reset_fail got=%b exp=00", fail_o); end
    total++; if (tap_sel_o !== '0) begin bad++; $display("FAIL reset_tapsel got=%h exp=0", tap_sel_o); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_sweep();
    bit to;
    int base;
    pass_mask[0] = rng(10, 20);
    pass_mask[1] = 32'hFFFF_FFFF;
    base = pcnt;
    run_cal(to);
    total++; if (to) begin bad++; $display("FAIL basic_timeout got=busy exp=done"); end
    total++; if (tap_sel_o !== {5'd15, 5'd15}) begin bad++; $display("FAIL basic_tapsel got=%h exp=%h", tap_sel_o, {5'd15, 5'd15}); end
    total++; if (fail_o !== 2'b00) begin bad++; $display("FAIL basic_fail got=%b exp=00", fail_o); end
    total++; if (done_o !== 1'b1) begin bad++; $display("FAIL basic_done got=%b exp=1", done_o); end
    total++; if (pcnt - base !== 66) begin bad++; $display("FAIL basic_pulses got=%0d exp=66", pcnt - base); end
    total++; if (stamp[base+1] - stamp[base] !== 82) begin bad++; $display("FAIL basic_tap_period got=%0d exp=82", stamp[base+1] - stamp[base]); end
    total++; if (pval[base+32] !== 5'd15 || psel[base+32] !== 2'b01) begin bad++; $display("FAIL basic_apply0 got=%0d/%b exp=15/01", pval[base+32], psel[base+32]); end
    total++; if (pval[base+40] !== 5'd7 || psel[base+40] !== 2'b10) begin bad++; $display("FAIL basic_sweep1 got=%0d/%b exp=7/10", pval[base+40], psel[base+40]); end
    total++; if (pval[base+65] !== 5'd15 || psel[base+65] !== 2'b10) begin bad++; $display("FAIL basic_apply1 got=%0d/%b exp=15/10", pval[base+65], psel[base+65]); end
  endtask

  task automatic test_tie_window();
    bit to;
    int base;
    pass_mask[0] = rng(0, 2) | rng(25, 31);
    pass_mask[1] = rng(4, 8) | rng(20, 24);
    base = pcnt;
    run_cal(to);
    total++; if (to) begin bad++; $display("FAIL tie_timeout got=busy exp=done"); end
    total++; if (tap_sel_o !== {5'd6, 5'd28}) begin bad++; $display("FAIL tie_tapsel got=%h exp=%h", tap_sel_o, {5'd6, 5'd28}); end
    total++; if (fail_o !== 2'b00) begin bad++; $display("FAIL tie_fail got=%b exp=00", fail_o); end
    total++; if (pcnt - base !== 66) begin bad++; $display("FAIL tie_pulses got=%0d exp=66", pcnt - base); end
  endtask

  task automatic test_fail_pattern();
    bit to;
    int base;
    pass_mask[0] = rng(10, 20);
    pass_mask[1] = 32'h0;
    base = pcnt;
    run_cal(to);
    total++; if (to) begin bad++; $display("FAIL nomatch_timeout got=busy exp=done"); end
    total++; if (fail_o !== 2'b10) begin bad++; $display("FAIL nomatch_fail got=%b exp=10", fail_o); end
    total++; if (tap_sel_o !== {5'd0, 5'd15}) begin bad++; $display("FAIL nomatch_tapsel got=%h exp=%h", tap_sel_o, {5'd0, 5'd15}); end
    total++; if (pval[base+65] !== 5'd0 || psel[base+65] !== 2'b10) begin bad++; $display("FAIL nomatch_apply1 got=%0d/%b exp=0/10", pval[base+65], psel[base+65]); end
  endtask

  task automatic test_valid_timeout();
    bit to;
    int base;
    pass_mask[0] = rng(10, 20);
    pass_mask[1] = 32'hFFFF_FFFF;
    adc_valid_i  = 2'b01;
    base = pcnt;
    run_cal(to);
    adc_valid_i  = 2'b11;
    total++; if (to) begin bad++; $display("FAIL tmo_timeout got=busy exp=done"); end
    total++; if (fail_o !== 2'b10) begin bad++; $display("FAIL tmo_fail got=%b exp=10", fail_o); end
    total++; if (tap_sel_o !== {5'd0, 5'd15}) begin bad++; $display("FAIL tmo_tapsel got=%h exp=%h", tap_sel_o, {5'd0, 5'd15}); end
    total++; if (pcnt - base !== 66) begin bad++; $display("FAIL tmo_pulses got=%0d exp=66", pcnt - base); end
    // 16 settle + 256 timeout + EVAL + LOAD
    total++; if (stamp[base+35] - stamp[base+34] !== 274) begin bad++; $display("FAIL tmo_tap_period got=%0d exp=274", stamp[base+35] - stamp[base+34]); end
  endtask

  task automatic test_manual();
    int base;
    mode_i         = 1'b1;
    man_tap_i      = 5'd7;
    man_chan_sel_i = 2'b01;
    base = pcnt;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL man_start_busy got=%b exp=0", busy_o); end
    total++; if (done_o !== 1'b1) begin bad++; $display("FAIL man_start_done got=%b exp=1", done_o); end
    man_load_i = 1'b1;
    tick();
    total++; if (delay_load_o !== 1'b1) begin bad++; $display("FAIL man_pulse got=%b exp=1", delay_load_o); end
    total++; if (delay_val_o !== 5'd7) begin bad++; $display("FAIL man_val got=%0d exp=7", delay_val_o); end
    total++; if (delay_chan_sel_o !== 2'b01) begin bad++; $display("FAIL man_sel got=%b exp=01", delay_chan_sel_o); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (delay_load_o !== 1'b0) begin bad++; $display("FAIL man_held_%0d got=%b exp=0", i, delay_load_o); end
    end
    man_load_i = 1'b0;
    ticks(2);
    total++; if (pcnt - base !== 1) begin bad++; $display("FAIL man_pulses got=%0d exp=1", pcnt - base); end
    total++; if (delay_val_o !== 5'd7) begin bad++; $display("FAIL man_val_hold got=%0d exp=7", delay_val_o); end
    mode_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit to;
    int base;
    pass_mask[0] = rng(10, 20);
    pass_mask[1] = 32'hFFFF_FFFF;
    base = pcnt;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if (pcnt - base >= 13) begin to = 1'b0; break; end
      tick();
    end
    total++; if (to) begin bad++; $display("FAIL mid_reach_tap12 got=%0d exp=13 pulses", pcnt - base); end
    ticks(20);
    rst = 1'b1;
    tick();
    total++; if ({delay_load_o, delay_val_o, delay_chan_sel_o} !== '0) begin bad++; $display("FAIL mid_rst_delay got=%b/%0d/%b exp=0/0/00", delay_load_o, delay_val_o, delay_chan_sel_o); end
    total++; if ({busy_o, done_o, fail_o, tap_sel_o} !== '0) begin bad++; $display("FAIL mid_rst_status got=%b/%b/%b/%h exp=0/0/00/0", busy_o, done_o, fail_o, tap_sel_o); end
    rst = 1'b0;
    tick();
    total++; if (delay_load_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL mid_after_rst got=%b/%b exp=0/0", delay_load_o, busy_o); end
    base = pcnt;
    run_cal(to);
    total++; if (to) begin bad++; $display("FAIL mid_rerun_timeout got=busy exp=done"); end
    total++; if (tap_sel_o !== {5'd15, 5'd15}) begin bad++; $display("FAIL mid_rerun_tapsel got=%h exp=%h", tap_sel_o, {5'd15, 5'd15}); end
    total++; if (pcnt - base !== 66) begin bad++; $display("FAIL mid_rerun_pulses got=%0d exp=66", pcnt - base); end
  endtask

  task automatic test_rdy();
    bit to;
    int base;
    pass_mask[0] = rng(10, 20);
    pass_mask[1] = 32'hFFFF_FFFF;
    idelay_rdy_i = 1'b0;
    base = pcnt;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    ticks(50);
    total++; if (pcnt - base !== 0) begin bad++; $display("FAIL rdy_noload got=%0d exp=0", pcnt - base); end
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL rdy_wait_busy got=%b exp=1", busy_o); end
    idelay_rdy_i = 1'b1;
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (pcnt - base >= 1) begin to = 1'b0; break; end
      tick();
    end
    total++; if (to) begin bad++; $display("FAIL rdy_first_load got=%0d exp=1", pcnt - base); end
    ticks(4);
    idelay_rdy_i = 1'b0;
    ticks(3);
    total++; if (pcnt - base !== 1 || busy_o !== 1'b1) begin bad++; $display("FAIL rdy_drop got=%0d/%b exp=1/1", pcnt - base, busy_o); end
    idelay_rdy_i = 1'b1;
    wait_done(to);
    total++; if (to) begin bad++; $display("FAIL rdy_timeout got=busy exp=done"); end
    total++; if (pcnt - base !== 67) begin bad++; $display("FAIL rdy_pulses got=%0d exp=67", pcnt - base); end
    total++; if (pval[base+1] !== 5'd0 || pval[base+2] !== 5'd1) begin bad++; $display("FAIL rdy_retap got=%0d,%0d exp=0,1", pval[base+1], pval[base+2]); end
    total++; if (tap_sel_o !== {5'd15, 5'd15} || fail_o !== 2'b00) begin bad++; $display("FAIL rdy_result got=%h/%b exp=%h/00", tap_sel_o, fail_o, {5'd15, 5'd15}); end
  endtask

  initial begin
    rst            = 1'b1;
    start_i        = 1'b0;
    mode_i         = 1'b0;
    man_tap_i      = '0;
    man_chan_sel_i = '0;
    man_load_i     = 1'b0;
    pattern_i      = 17'h1A5C3;
    adc_valid_i    = 2'b11;
    idelay_rdy_i   = 1'b1;
    pass_mask[0]   = '0;
    pass_mask[1]   = '0;

    test_reset();
    test_basic_sweep();
    test_tie_window();
    test_fail_pattern();
    test_valid_timeout();
    test_manual();
    test_reset_mid();
    test_rdy();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
